// File: rtl/sobel_edge_core.sv
// Streaming 3x3 Sobel edge stage fed by sobel_fifo (1-cycle read latency).
// Pops grayscale pixels into a 2-entry skid, builds a 3x3 window from two
// line buffers, and emits |Gx|+|Gy| (saturated or thresholded) per interior
// pixel over a valid/ready handshake.
module sobel_edge_core #(
   parameter int unsigned IMG_W     = 640,
   parameter int unsigned IMG_H     = 480,
   parameter bit          THRESH_EN = 1'b1,
   parameter logic [7:0]  THRESH    = 8'd100
) (
   input  logic       clk,
   input  logic       tb_rst,
   output logic       fifo_rd_en,
   input  logic [7:0] fifo_rd_data,
   input  logic       fifo_rd_empty,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sof,
   output logic       out_eol
);

   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic              rd_en_q;
   logic [1:0]        skid_cnt;
   logic [7:0]        skid0;
   logic [7:0]        skid1;
   logic              stall;
   logic              pop;

   logic [XW-1:0]     x;
   logic [YW-1:0]     y;

   logic [7:0]        lb0 [IMG_W];
   logic [7:0]        lb1 [IMG_W];
   logic [7:0]        w   [3][3];

   logic              win_valid;
   logic              win_sof;
   logic              win_eol;

   logic [9:0]        sum_l;
   logic [9:0]        sum_r;
   logic [9:0]        sum_t;
   logic [9:0]        sum_b;
   logic signed [10:0] gx_c;
   logic signed [10:0] gy_c;
   logic signed [10:0] gx;
   logic signed [10:0] gy;
   logic              g_valid;
   logic              g_sof;
   logic              g_eol;

   logic [10:0]       abs_x;
   logic [10:0]       abs_y;
   logic [10:0]       mag;
   logic [7:0]        sat;
   logic [7:0]        res;

   // Handshake stall, pixel pop and FIFO read request.
   // The pop of this cycle is credited so a steady read/pop keeps one pixel
   // per clock while the skid can still never hold more than two entries.
   always_comb begin
      stall      = out_valid && !out_ready;
      pop        = (skid_cnt != 2'd0) && !stall;
      fifo_rd_en = !tb_rst && !fifo_rd_empty &&
                   ((3'(skid_cnt) - 3'(pop) + 3'(rd_en_q)) < 3'd2);
   end

   // Two-entry skid: capture read data one cycle after the strobe, pop from head.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         rd_en_q  <= 1'b0;
         skid_cnt <= '0;
         skid0    <= '0;
         skid1    <= '0;
      end else begin
         rd_en_q <= fifo_rd_en;
         case ({rd_en_q, pop})
            2'b10: begin
               if (skid_cnt == 2'd0) skid0 <= fifo_rd_data;
               else                  skid1 <= fifo_rd_data;
               skid_cnt <= skid_cnt + 2'd1;
            end
            2'b01: begin
               skid0    <= skid1;
               skid_cnt <= skid_cnt - 2'd1;
            end
            2'b11: begin
               if (skid_cnt == 2'd1) begin
                  skid0 <= fifo_rd_data;
               end else begin
                  skid0 <= skid1;
                  skid1 <= fifo_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Raster position of the pixel being popped.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         x <= '0;
         y <= '0;
      end else if (pop) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // Line buffers (read-before-write) and 3x3 window shift; contents not reset.
   always_ff @(posedge clk) begin
      if (pop) begin
         lb0[x]  <= lb1[x];
         lb1[x]  <= skid0;
         w[0][0] <= w[0][1];
         w[1][0] <= w[1][1];
         w[2][0] <= w[2][1];
         w[0][1] <= w[0][2];
         w[1][1] <= w[1][2];
         w[2][1] <= w[2][2];
         w[0][2] <= lb0[x];
         w[1][2] <= lb1[x];
         w[2][2] <= skid0;
      end
   end

   // Window-stage qualifiers: only full windows inside one row are emitted.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         win_valid <= 1'b0;
         win_sof   <= 1'b0;
         win_eol   <= 1'b0;
      end else if (!stall) begin
         win_valid <= pop && (x >= XW'(2)) && (y >= YW'(2));
         win_sof   <= (x == XW'(2)) && (y == YW'(2));
         win_eol   <= (x == X_LAST);
      end
   end

   // Sobel kernels as column/row weighted sums.
   always_comb begin
      sum_l = 10'(w[0][0]) + {1'b0, w[1][0], 1'b0} + 10'(w[2][0]);
      sum_r = 10'(w[0][2]) + {1'b0, w[1][2], 1'b0} + 10'(w[2][2]);
      sum_t = 10'(w[0][0]) + {1'b0, w[0][1], 1'b0} + 10'(w[0][2]);
      sum_b = 10'(w[2][0]) + {1'b0, w[2][1], 1'b0} + 10'(w[2][2]);
      gx_c  = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
      gy_c  = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
   end

   // Gradient register stage.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         g_valid <= 1'b0;
         g_sof   <= 1'b0;
         g_eol   <= 1'b0;
         gx      <= '0;
         gy      <= '0;
      end else if (!stall) begin
         g_valid <= win_valid;
         g_sof   <= win_sof;
         g_eol   <= win_eol;
         gx      <= gx_c;
         gy      <= gy_c;
      end
   end

   // Magnitude, saturation and optional binarisation.
   always_comb begin
      abs_x = gx[10] ? $unsigned(-gx) : $unsigned(gx);
      abs_y = gy[10] ? $unsigned(-gy) : $unsigned(gy);
      mag   = abs_x + abs_y;
      sat   = (mag > 11'd255) ? 8'hFF : mag[7:0];
      if (THRESH_EN) res = (mag >= {3'b000, THRESH}) ? 8'hFF : 8'h00;
      else           res = sat;
   end

   // Output register; held while the consumer stalls.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
      end else if (!stall) begin
         out_valid <= g_valid;
         out_data  <= res;
         out_sof   <= g_sof;
         out_eol   <= g_eol;
      end
   end

endmodule

// File: tb/tb_sobel_edge_core.sv
// Bench for sobel_edge_core: a thresholded and a saturating instance share one
// FIFO model and one ready line; outputs are scored against a frame-level
// Sobel model computed directly from the image array.
module tb_sobel_edge_core;

   localparam int W    = 8;
   localparam int H    = 6;
   localparam int THR  = 100;
   localparam int NPIX = (W - 2) * (H - 2);

   logic       clk;
   logic       tb_rst;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_empty;
   logic       out_ready;
   logic       rd_en_a, rd_en_b;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       sof_a, sof_b;
   logic       eol_a, eol_b;

   typedef struct {
      int dt;
      int ds;
      bit sof;
      bit eol;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fq[$];
   int         img [H][W];

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         ready_mode = 0;
   int         sparse_mode = 0;
   bit         loose = 1'b0;
   bit         have_pend = 1'b0;
   logic [7:0] pend_data;
   int         n_reads = 0;
   int         frame_outs = 0;
   int         first_cyc = -1;
   int         last_cyc = -1;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_a, prev_b;
   logic       prev_sof, prev_eol;

   sobel_edge_core #(.IMG_W(W), .IMG_H(H), .THRESH_EN(1'b1), .THRESH(8'd100)) dut_a (
      .clk(clk), .tb_rst(tb_rst), .fifo_rd_en(rd_en_a), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_empty(fifo_rd_empty), .out_data(data_a), .out_valid(valid_a),
      .out_ready(out_ready), .out_sof(sof_a), .out_eol(eol_a)
   );

   sobel_edge_core #(.IMG_W(W), .IMG_H(H), .THRESH_EN(1'b0), .THRESH(8'd100)) dut_b (
      .clk(clk), .tb_rst(tb_rst), .fifo_rd_en(rd_en_b), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_empty(fifo_rd_empty), .out_data(data_b), .out_valid(valid_b),
      .out_ready(out_ready), .out_sof(sof_b), .out_eol(eol_b)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Reference: Sobel on the whole frame, interior pixels in raster order.
   task automatic model_frame();
      for (int cy = 1; cy <= H - 2; cy++) begin
         for (int cx = 1; cx <= W - 2; cx++) begin
            int gx, gy, mag;
            exp_t e;
            gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
            gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
            mag   = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            e.ds  = (mag > 255) ? 255 : mag;
            e.dt  = (mag >= THR) ? 255 : 0;
            e.sof = (cx == 1) && (cy == 1);
            e.eol = (cx == W - 2);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_pixels();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            fq.push_back(8'(img[yy][xx]));
   endtask

   task automatic push_frame();
      push_pixels();
      model_frame();
   endtask

   task automatic fill_flat(input int v);
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            img[yy][xx] = v;
   endtask

   task automatic fill_vstep();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            img[yy][xx] = (xx >= 4) ? 255 : 0;
   endtask

   task automatic fill_hstep();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            img[yy][xx] = (yy >= 3) ? 255 : 0;
   endtask

   task automatic fill_rand(input bit smooth);
      int base;
      base = int'($urandom_range(60, 180));
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            img[yy][xx] = smooth ? base + int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
   endtask

   task automatic start(input int rmode, input int smode);
      @(negedge clk);
      #4;
      ready_mode  = rmode;
      sparse_mode = smode;
      frame_outs  = 0;
      first_cyc   = -1;
      last_cyc    = -1;
   endtask

   task automatic finish_frames(input string tag, input int nframes);
      for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge clk);
      check({tag, "_drained"}, exp_q.size(), 0);
      repeat (12) @(negedge clk);
      check({tag, "_count"}, frame_outs, NPIX * nframes);
      exp_q.delete();
   endtask

   // FIFO model, ready/empty pattern drive and output scoreboard, once per cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (have_pend) begin
            fifo_rd_data = pend_data;
            have_pend    = 1'b0;
         end
         cyc++;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         case (sparse_mode)
            0:       fifo_rd_empty = (fq.size() == 0);
            1:       fifo_rd_empty = (fq.size() == 0) || (cyc % 4 != 0);
            default: fifo_rd_empty = (fq.size() == 0) || ($urandom_range(0, 2) == 0);
         endcase
         #1;
         check("rd_en_twin", rd_en_b, rd_en_a);
         check("skid_le2", (dut_a.skid_cnt > 2'd2) ? 1 : 0, 0);
         if (rd_en_a) begin
            check("rd_while_empty", fifo_rd_empty, 0);
            if (fq.size() != 0) begin
               pend_data = fq.pop_front();
               have_pend = 1'b1;
               n_reads++;
            end
         end
         if (prev_stall) begin
            check("hold_valid", valid_a, 1);
            check("hold_data_a", data_a, prev_a);
            check("hold_data_b", data_b, prev_b);
            check("hold_sof", sof_a, prev_sof);
            check("hold_eol", eol_a, prev_eol);
         end
         check("valid_twin", valid_b, valid_a);
         if (valid_a && out_ready) begin
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("data_thr", data_a, e.dt);
               check("data_sat", data_b, e.ds);
               check("sof_a", sof_a, e.sof);
               check("eol_a", eol_a, e.eol);
               check("sof_b", sof_b, e.sof);
               check("eol_b", eol_b, e.eol);
               frame_outs++;
               if (first_cyc < 0) first_cyc = cyc;
               last_cyc = cyc;
            end else if (loose) begin
               check("flat_data", data_a, 0);
            end else begin
               check("unexpected_out", valid_a, 0);
            end
         end
         prev_stall = valid_a && !out_ready;
         prev_a     = data_a;
         prev_b     = data_b;
         prev_sof   = sof_a;
         prev_eol   = eol_a;
      end
   end

   // Scenario sequence.
   initial begin
      tb_rst        = 1'b1;
      fifo_rd_data  = '0;
      fifo_rd_empty = 1'b1;
      out_ready     = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_valid", valid_a, 0);
      check("rst_data", data_a, 0);
      check("rst_sof", sof_a, 0);
      check("rst_eol", eol_a, 0);
      check("rst_rd_en", rd_en_a, 0);
      #1 tb_rst = 1'b0;

      // Flat frame at full rate: all zero, one pixel per clock.
      start(0, 0);
      fill_flat(128);
      push_frame();
      finish_frames("flat", 1);
      check("flat_span", last_cyc - first_cyc, 29);

      // Vertical step.
      start(0, 0);
      fill_vstep();
      push_frame();
      finish_frames("vstep", 1);

      // Horizontal step.
      start(0, 0);
      fill_hstep();
      push_frame();
      finish_frames("hstep", 1);

      // Vertical step under 1-on/2-off backpressure.
      start(1, 0);
      fill_vstep();
      push_frame();
      finish_frames("bp", 1);

      // Vertical step with the FIFO empty 3 of every 4 cycles.
      start(0, 1);
      fill_vstep();
      push_frame();
      finish_frames("sparse", 1);

      // Reset part way into a frame, then a complete flat frame.
      start(0, 0);
      loose   = 1'b1;
      n_reads = 0;
      fill_flat(128);
      push_pixels();
      for (int i = 0; i < 500 && n_reads < 20; i++) @(negedge clk);
      check("pre_rst_reads", (n_reads >= 20) ? 1 : 0, 1);
      @(negedge clk);
      #3 tb_rst = 1'b1;
      prev_stall = 1'b0;
      #1;
      check("midrst_valid_a", valid_a, 0);
      check("midrst_valid_b", valid_b, 0);
      check("midrst_data_a", data_a, 0);
      check("midrst_data_b", data_b, 0);
      check("midrst_sof", sof_a, 0);
      check("midrst_rd_en", rd_en_a, 0);
      fq.delete();
      have_pend = 1'b0;
      repeat (2) @(negedge clk);
      #3 tb_rst = 1'b0;
      loose = 1'b0;
      start(0, 0);
      fill_flat(128);
      push_frame();
      finish_frames("post_rst", 1);

      // Random images, back-to-back frames, random ready and empty patterns.
      for (int k = 0; k < 6; k++) begin
         start((k % 2 == 0) ? 2 : 0, k % 3);
         fill_rand(k % 2 == 1);
         push_frame();
         fill_rand(k % 3 == 0);
         push_frame();
         finish_frames("rand", 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
